sys_hex_display: RTL

Seven-digit multiplexed seven-segment driver that sits directly downstream of the CPU system's 27-bit `SYS_leds` debug bus. It captures the 27-bit value into a snapshot register and time-multiplexes its seven hex nibbles onto a common-anode display. Between digits it inserts an anti-ghosting blank gap. A hold input freezes the snapshot so a value can be read while the CPU keeps clocking.

---
 rtl/disp_pkg.sv | 39 +++
 rtl/sys_hex_display_hex_to_seg.sv | 11 +
 rtl/sys_hex_display.sv | 118 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants, hex segment table, scan FSM states and digit helper
// for the seven-digit multiplexed hex display driver.
package disp_pkg;

   localparam int NUM_DIGITS = 7;
   localparam int VALUE_W    = 27;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [6:0] AN_OFF  = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for 0..F
   localparam logic [6:0] HEX_SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic {
      GAP = 1'b0,
      ON  = 1'b1
   } dispState_e;

   // Digit 6 carries only the three MSBs of the 27-bit value
   function automatic logic [3:0] digitOf(input logic [VALUE_W-1:0] value,
                                          input logic [2:0]         idx);
      case (idx)
         3'd0:    return value[3:0];
         3'd1:    return value[7:4];
         3'd2:    return value[11:8];
         3'd3:    return value[15:12];
         3'd4:    return value[19:16];
         3'd5:    return value[23:20];
         3'd6:    return {1'b0, value[26:24]};
         default: return 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/sys_hex_display_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
   import disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/sys_hex_display.sv
// Seven-digit multiplexed hex display with snapshot/hold and anti-ghost gap.
// Optional leading-zero blanking is enabled by defining SYS_DISP_LZ_BLANK_EN.
module sys_hex_display
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GAP_CYCLES  = 1000
) (
   input  logic               SYS_clk,
   input  logic               SYS_reset,
   input  logic [VALUE_W-1:0] DISP_value,
   input  logic               DISP_valid,
   input  logic               DISP_hold,
   output logic [6:0]         DISP_an,
   output logic [6:0]         DISP_seg,
   output logic               DISP_dp
);

   localparam int              CW          = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]   CNT_LAST    = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]   GAP_LAST    = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [2:0]      IDX_LAST    = 3'(NUM_DIGITS - 1);
   localparam dispState_e      SLOT_START  = (GAP_CYCLES > 0) ? GAP : ON;

   logic [VALUE_W-1:0] snap_q, snap_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         idx_q, idx_d;
   dispState_e         state_q, state_d;
   logic [6:0]         an_q, an_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;

   logic [3:0]         nibble;
   logic [6:0]         segDecoded;
   logic               digitBlank;

   always_comb begin
      snap_d = snap_q;
      if (DISP_valid && !DISP_hold) begin
         snap_d = DISP_value;
      end
   end

   // Slot wrap takes priority over the gap-end transition
   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      state_d = state_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
         state_d = SLOT_START;
      end else if (state_q == GAP && cnt_q == GAP_LAST) begin
         state_d = ON;
      end
   end

   assign nibble = digitOf(snap_q, idx_q);

   hex_to_seg u_hexToSeg (
      .nibble_i (nibble),
      .seg_o    (segDecoded)
   );

`ifdef SYS_DISP_LZ_BLANK_EN
   // A digit blanks when it and every higher digit are zero; digit 0 never blanks
   logic zeroAbove;

   always_comb begin
      zeroAbove  = 1'b1;
      digitBlank = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zeroAbove = zeroAbove && (digitOf(snap_q, 3'(i)) == 4'h0);
         if (idx_q == 3'(i)) begin
            digitBlank = zeroAbove;
         end
      end
   end
`else
   assign digitBlank = 1'b0;
`endif

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_q == ON) begin
         an_d  = ~(7'b0000001 << idx_q);
         seg_d = digitBlank ? SEG_OFF : segDecoded;
         dp_d  = !((idx_q == IDX_LAST) && !digitBlank);
      end
   end

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         snap_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         state_q <= SLOT_START;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign DISP_an  = an_q;
   assign DISP_seg = seg_q;
   assign DISP_dp  = dp_q;

endmodule
